// File: rtl/bk_pkg.sv
// Shared constants, FSM state encoding and the A/B bit-interleave helper
// for the Brent-Kung operand packer.
package bk_pkg;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned NIB   = 4;
  localparam int unsigned NB    = WIDTH / NIB;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned OP_W  = 2 * WIDTH;

  typedef logic [OP_W-1:0] pair_t;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  // Adder input ordering: bit 2i carries A[i], bit 2i+1 carries B[i].
  function automatic pair_t interleave(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    pair_t r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bk_operand_packer_if.sv
// Nibble-serial input stream and interleaved operand output of the packer.
interface bk_operand_packer_if;

  logic                     in_valid;
  logic                     in_ready;
  logic [bk_pkg::NIB-1:0]   in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [bk_pkg::OP_W-1:0]  out_operands;
  logic [1:0]               occupancy;
  logic                     err_framing;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_operands, occupancy, err_framing
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_operands, occupancy, err_framing
  );

endinterface

// File: rtl/bk_pair_fifo.sv
// Two-entry register FIFO for assembled operand pairs; head entry is read
// straight from a flop so the adder sees a stable registered bus.
module bk_pair_fifo
  import bk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pair_t      push_data,
  input  logic       pop,
  output pair_t      rd_data,
  output logic [1:0] occupancy
);

  pair_t      mem0_q, mem0_d;
  pair_t      mem1_q, mem1_d;
  logic [1:0] occ_q, occ_d;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    occ_d  = occ_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) mem0_d = push_data;
        else               mem1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        mem0_d = mem1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Pop and push together: occupancy holds, new data lands behind the survivor.
        if (occ_q == 2'd1) begin
          mem0_d = push_data;
        end else begin
          mem0_d = mem1_q;
          mem1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q <= '0;
      mem1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      occ_q  <= occ_d;
    end
  end

  assign rd_data   = mem0_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/bk_operand_packer.sv
// Assembles nibble-serial A then B operands into the interleaved Brent-Kung
// adder input bus and queues them in a 2-entry FIFO.
module bk_operand_packer
  import bk_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  bk_operand_packer_if.slave bus
);

  if ((WIDTH % NIB) != 0) begin : g_bad_nib
    $error("bk_operand_packer: WIDTH must be a multiple of NIB");
  end
  if (DEPTH != 2) begin : g_bad_depth
    $error("bk_operand_packer: only DEPTH=2 is supported");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               in_ready_q, in_ready_d;
  logic               err_q, err_d;
  logic               beat, push, pop, last_beat;
  logic [1:0]         occupancy;
  pair_t              head;

  assign beat      = bus.in_valid & in_ready_q;
  assign pop       = (occupancy != 2'd0) & bus.out_ready;
  assign last_beat = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_A: begin
        if (beat) begin
          if (bus.in_last) begin
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            a_d[cnt_q*NIB +: NIB] = bus.in_data;
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            if (last_beat) state_d = S_B;
          end
        end
      end
      S_B: begin
        if (beat) begin
          // in_last must coincide exactly with the final B nibble.
          if (bus.in_last != last_beat) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_A;
          end else begin
            b_d[cnt_q*NIB +: NIB] = bus.in_data;
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            if (last_beat) state_d = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        if ((occupancy != 2'd2) || pop) begin
          push    = 1'b1;
          state_d = S_A;
        end
      end
      default: begin
        state_d = S_A;
        cnt_d   = '0;
      end
    endcase
    in_ready_d = (state_d != S_PUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  bk_pair_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (interleave(a_q, b_q)),
    .pop       (pop),
    .rd_data   (head),
    .occupancy (occupancy)
  );

  assign bus.in_ready     = in_ready_q;
  assign bus.err_framing  = err_q;
  assign bus.out_valid    = (occupancy != 2'd0);
  assign bus.out_operands = head;
  assign bus.occupancy    = occupancy;

endmodule

// File: tb/tb_bk_operand_packer.sv
// Directed bench for bk_operand_packer: assembly, interleave, backpressure,
// framing errors and mid-operation reset against hand-computed values.
module tb_bk_operand_packer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bk_operand_packer_if bus_if ();

  bk_operand_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    while (bus_if.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("beat_ready", 32'(bus_if.in_ready), 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    bus_if.in_last  = last;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic send_pair(input logic [11:0] a, input logic [11:0] b);
    send_beat(a[3:0],  1'b0);
    send_beat(a[7:4],  1'b0);
    send_beat(a[11:8], 1'b0);
    send_beat(b[3:0],  1'b0);
    send_beat(b[7:4],  1'b0);
    send_beat(b[11:8], 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus_if.in_ready),     32'd1);
    chk({tag, "_out_valid"}, 32'(bus_if.out_valid),    32'd0);
    chk({tag, "_operands"},  32'(bus_if.out_operands), 32'h0);
    chk({tag, "_occ"},       32'(bus_if.occupancy),    32'd0);
    chk({tag, "_err"},       32'(bus_if.err_framing),  32'd0);
  endtask

  logic [11:0] ea, eb;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_last   = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // A=FFF, B=000
    send_pair(12'hFFF, 12'h000);
    chk("t1_not_yet_valid", 32'(bus_if.out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(bus_if.out_valid), 32'd1);
    chk("t1_operands", 32'(bus_if.out_operands), 32'h555555);
    @(negedge clk);
    chk("t1_popped", 32'(bus_if.out_valid), 32'd0);

    // A=000, B=FFF
    send_pair(12'h000, 12'hFFF);
    @(negedge clk);
    chk("t2_operands", 32'(bus_if.out_operands), 32'hAAAAAA);
    @(negedge clk);

    // A=ABC, B=123
    send_pair(12'hABC, 12'h123);
    @(negedge clk);
    chk("t3_operands", 32'(bus_if.out_operands), 32'h464D5A);
    for (int i = 0; i < 12; i++) begin
      ea[i] = bus_if.out_operands[2*i];
      eb[i] = bus_if.out_operands[2*i+1];
    end
    chk("t3_sum", 32'({1'b0, ea} + {1'b0, eb}), 32'h0BDF);
    @(negedge clk);

    // Backpressure: three pairs into a 2-deep FIFO, then drain
    bus_if.out_ready = 1'b0;
    send_pair(12'h001, 12'h000);
    send_pair(12'h000, 12'h001);
    send_pair(12'hFFF, 12'hFFF);
    chk("bp_occ_full", 32'(bus_if.occupancy), 32'd2);
    chk("bp_in_ready_low", 32'(bus_if.in_ready), 32'd0);
    chk("bp_head_p1", 32'(bus_if.out_operands), 32'h000001);
    @(negedge clk);
    chk("bp_stall_ready", 32'(bus_if.in_ready), 32'd0);
    chk("bp_stall_head", 32'(bus_if.out_operands), 32'h000001);
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pushpop_occ", 32'(bus_if.occupancy), 32'd2);
    chk("bp_head_p2", 32'(bus_if.out_operands), 32'h000002);
    chk("bp_ready_back", 32'(bus_if.in_ready), 32'd1);
    @(negedge clk);
    chk("bp_occ_one", 32'(bus_if.occupancy), 32'd1);
    chk("bp_head_p3", 32'(bus_if.out_operands), 32'hFFFFFF);
    @(negedge clk);
    chk("bp_drained", 32'(bus_if.out_valid), 32'd0);

    // Framing: in_last on the third A nibble
    send_beat(4'h1, 1'b0);
    send_beat(4'h2, 1'b0);
    send_beat(4'h3, 1'b1);
    chk("fr1_err", 32'(bus_if.err_framing), 32'd1);
    chk("fr1_occ", 32'(bus_if.occupancy), 32'd0);
    @(negedge clk);
    chk("fr1_err_pulse", 32'(bus_if.err_framing), 32'd0);
    chk("fr1_no_write", 32'(bus_if.out_valid), 32'd0);
    send_pair(12'h0F0, 12'h00F);
    @(negedge clk);
    chk("fr1_clean_pair", 32'(bus_if.out_operands), 32'h0055AA);
    @(negedge clk);

    // Framing: in_last missing on the final B nibble
    for (int i = 0; i < 6; i++) send_beat(4'h7, 1'b0);
    chk("fr2_err", 32'(bus_if.err_framing), 32'd1);
    @(negedge clk);
    chk("fr2_no_write", 32'(bus_if.occupancy), 32'd0);

    // Reset mid-B-operand with one FIFO entry held
    bus_if.out_ready = 1'b0;
    send_pair(12'hFFF, 12'h000);
    @(negedge clk);
    chk("mr_occ_one", 32'(bus_if.occupancy), 32'd1);
    send_beat(4'hC, 1'b0);
    send_beat(4'hB, 1'b0);
    send_beat(4'hA, 1'b0);
    send_beat(4'h9, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mr");
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    send_pair(12'h123, 12'h000);
    @(negedge clk);
    chk("mr_fresh_pair", 32'(bus_if.out_operands), 32'h010405);
    @(negedge clk);
    chk("mr_fresh_popped", 32'(bus_if.occupancy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
